// File: rtl/cpu_defs.sv
// Shared CPU front-end types: fetch/decode pipe register, exception redirect
// request, virtual address type and the IF-stage FSM encoding.
package cpu_defs;

  typedef logic [31:0] virt_t;

  localparam virt_t RESET_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic  valid;
    virt_t target;
  } except_req_t;

  typedef struct packed {
    logic        valid;
    virt_t       vaddr;
    logic [31:0] inst;
    logic        adel;
  } pipe_if_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD,
    DROP
  } if_state_t;

  function automatic virt_t pc_plus4(virt_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_gen.sv
// Program counter for the IF stage: holds pc_q, remembers a pending branch
// redirect until the delay slot returns, and picks exception > redirect > +4.
module pc_gen
  import cpu_defs::*;
#(
  parameter virt_t RESET_PC = cpu_defs::RESET_PC
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  except_valid,
  input  virt_t except_target,
  input  logic  br_valid,
  input  virt_t br_target,
  input  logic  advance,
  output virt_t pc_q
);

  logic  redir_pend;
  virt_t redir_pc;
  virt_t pc_d;

  // A branch seen in the same cycle as the delay-slot response wins directly.
  always_comb begin
    pc_d = pc_q;
    if (except_valid) begin
      pc_d = except_target;
    end else if (advance) begin
      if (br_valid)
        pc_d = br_target;
      else if (redir_pend)
        pc_d = redir_pc;
      else
        pc_d = pc_plus4(pc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      redir_pend <= 1'b0;
      redir_pc   <= RESET_PC;
    end else begin
      pc_q <= pc_d;
      if (except_valid || advance) begin
        redir_pend <= 1'b0;
      end else if (br_valid) begin
        redir_pend <= 1'b1;
        redir_pc   <= br_target;
      end
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// IF stage: one blocking icache request at a time, feeding pipe_if to decode.
// Optional IF_ADDR_ERR_CHECK_EN raises adel for a misaligned pc_q instead of fetching.
module inst_fetch
  import cpu_defs::*;
#(
  parameter virt_t RESET_PC = cpu_defs::RESET_PC,
  parameter int    ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready_i,
  input  except_req_t       except_req,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              ic_req_valid,
  output logic [ADDR_W-1:0] ic_req_vaddr,
  input  logic              ic_req_ready,
  input  logic              ic_resp_valid,
  input  logic [31:0]       ic_resp_inst,
  output pipe_if_t          pipe_if
);

  if_state_t state_q, state_d;
  pipe_if_t  pipe_q, pipe_d;
  pipe_if_t  hold_q, hold_d;
  virt_t     pc_q;
  logic      advance;
  logic      slot_free;
  logic      req_ok;

  pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .clk          (clk),
    .rst          (rst),
    .except_valid (except_req.valid),
    .except_target(except_req.target),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .advance      (advance),
    .pc_q         (pc_q)
  );

`ifdef IF_ADDR_ERR_CHECK_EN
  logic adel_sent_q, adel_sent_d;
  assign req_ok = (pc_q[1:0] == 2'b00);
`else
  assign req_ok = 1'b1;
`endif

  assign slot_free    = !pipe_q.valid || ready_i;
  assign ic_req_vaddr = pc_q;
  assign pipe_if      = pipe_q;

  always_comb begin
    state_d      = state_q;
    pipe_d       = pipe_q;
    hold_d       = hold_q;
    advance      = 1'b0;
    ic_req_valid = 1'b0;
`ifdef IF_ADDR_ERR_CHECK_EN
    adel_sent_d  = adel_sent_q;
`endif
    if (ready_i)
      pipe_d.valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_ok && !rst) begin
          ic_req_valid = 1'b1;
          if (ic_req_ready)
            state_d = WAIT;
        end
`ifdef IF_ADDR_ERR_CHECK_EN
        // A misaligned PC is reported once and then parked until redirected.
        else if (!req_ok && slot_free && !adel_sent_q) begin
          pipe_d      = '{valid: 1'b1, vaddr: pc_q, inst: 32'd0, adel: 1'b1};
          adel_sent_d = 1'b1;
        end
`endif
      end
      WAIT: begin
        if (ic_resp_valid) begin
          advance = 1'b1;
          if (slot_free) begin
            pipe_d  = '{valid: 1'b1, vaddr: pc_q, inst: ic_resp_inst, adel: 1'b0};
            state_d = IDLE;
          end else begin
            hold_d  = '{valid: 1'b1, vaddr: pc_q, inst: ic_resp_inst, adel: 1'b0};
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (ready_i) begin
          pipe_d  = hold_q;
          hold_d  = '0;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (ic_resp_valid)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush must still swallow the response of any request left in flight.
    if (except_req.valid) begin
      pipe_d  = '0;
      hold_d  = '0;
      advance = 1'b0;
`ifdef IF_ADDR_ERR_CHECK_EN
      adel_sent_d = 1'b0;
`endif
      if (((state_q == WAIT || state_q == DROP) && !ic_resp_valid) ||
          (ic_req_valid && ic_req_ready))
        state_d = DROP;
      else
        state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pipe_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_d;
      hold_q  <= hold_d;
    end
  end

`ifdef IF_ADDR_ERR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)
      adel_sent_q <= 1'b0;
    else
      adel_sent_q <= adel_sent_d;
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: behavioural icache with credits and
// configurable latency, plus request and pipe_if scoreboards.
module tb_inst_fetch;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready_i = 1'b1;
  except_req_t except_req = '0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        ic_req_valid;
  logic [31:0] ic_req_vaddr;
  logic        ic_req_ready;
  logic        ic_resp_valid = 1'b0;
  logic [31:0] ic_resp_inst = '0;
  pipe_if_t    pipe_if;

  int checks = 0;
  int passes = 0;

  pipe_if_t exp_out[$];
  virt_t    exp_req[$];

  int    credits = 0;
  int    resp_lat = 0;
  int    accept_count = 0;
  bit    pend = 1'b0;
  int    cnt = 0;
  virt_t paddr = '0;
  bit    acc_s = 1'b0;
  virt_t acc_addr = '0;
  virt_t req_e;
  pipe_if_t out_e;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .ready_i      (ready_i),
    .except_req   (except_req),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .ic_req_valid (ic_req_valid),
    .ic_req_vaddr (ic_req_vaddr),
    .ic_req_ready (ic_req_ready),
    .ic_resp_valid(ic_resp_valid),
    .ic_resp_inst (ic_resp_inst),
    .pipe_if      (pipe_if)
  );

  always #5 clk = ~clk;

  assign ic_req_ready = (credits != 0);

  function automatic logic [31:0] inst_of(virt_t a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic pipe_if_t exp_item(virt_t a);
    return '{valid: 1'b1, vaddr: a, inst: inst_of(a), adel: 1'b0};
  endfunction

  // icache model: accept sampled mid-cycle, response after resp_lat idle cycles.
  always @(negedge clk) begin
    acc_s    = ic_req_valid && ic_req_ready && !rst;
    acc_addr = ic_req_vaddr;
  end

  always @(posedge clk) begin
    #2;
    ic_resp_valid = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (acc_s) begin
        accept_count++;
        credits--;
        checks++;
        if (exp_req.size() == 0) begin
          $display("[TB] FAIL req_addr: unexpected request %h, none required", acc_addr);
        end else begin
          req_e = exp_req.pop_front();
          if (acc_addr !== req_e)
            $display("[TB] FAIL req_addr: got %h required %h", acc_addr, req_e);
          else
            passes++;
        end
        pend = 1'b1;
        cnt  = resp_lat;
        paddr = acc_addr;
      end
      if (pend) begin
        if (cnt == 0) begin
          ic_resp_valid = 1'b1;
          ic_resp_inst  = inst_of(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Output scoreboard: every pipe_if consumed by decode must match the queue head.
  always @(negedge clk) begin
    if (!rst && pipe_if.valid && ready_i) begin
      checks++;
      if (exp_out.size() == 0) begin
        $display("[TB] FAIL pipe_out: unexpected output %h, none required", pipe_if);
      end else begin
        out_e = exp_out.pop_front();
        if (pipe_if !== out_e)
          $display("[TB] FAIL pipe_out: got %h required %h", pipe_if, out_e);
        else
          passes++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_both(virt_t a);
    exp_req.push_back(a);
    exp_out.push_back(exp_item(a));
  endtask

  task automatic wait_idle(int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_out.size() == 0 && exp_req.size() == 0 && credits == 0 && !pend)
        break;
      step();
    end
    checks++;
    if (exp_out.size() != 0 || exp_req.size() != 0 || credits != 0 || pend)
      $display("[TB] FAIL idle_timeout: outs left %0d reqs left %0d, required 0 and 0",
               exp_out.size(), exp_req.size());
    else
      passes++;
    step();
    step();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    ready_i = 1'b1;
    br_valid = 1'b0;
    except_req = '0;
    credits = 0;
    resp_lat = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    credits = 0;
    step();
    @(negedge clk);
    checks++;
    if (ic_req_valid !== 1'b0) $display("[TB] FAIL rst_req: got %b required 0", ic_req_valid);
    else passes++;
    checks++;
    if (pipe_if !== '0) $display("[TB] FAIL rst_pipe: got %h required 0", pipe_if);
    else passes++;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ic_req_valid !== 1'b1) $display("[TB] FAIL idle_req: got %b required 1", ic_req_valid);
    else passes++;
    checks++;
    if (ic_req_vaddr !== 32'hBFC0_0000)
      $display("[TB] FAIL rst_pc: got %h required bfc00000", ic_req_vaddr);
    else passes++;
    step();
  endtask

  task automatic test_sequential();
    logic [7:0] exp_valid;
    exp_valid = 8'b0101_0100;
    reset_dut();
    push_both(32'hBFC0_0000);
    push_both(32'hBFC0_0004);
    push_both(32'hBFC0_0008);
    credits = 3;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (pipe_if.valid !== exp_valid[i])
        $display("[TB] FAIL seq_valid[%0d]: got %b required %b", i, pipe_if.valid, exp_valid[i]);
      else
        passes++;
    end
    wait_idle(50);
  endtask

  task automatic test_stall();
    pipe_if_t snap;
    bit found;
    reset_dut();
    ready_i = 1'b0;
    push_both(32'hBFC0_0000);
    push_both(32'hBFC0_0004);
    push_both(32'hBFC0_0008);
    credits = 3;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pipe_if.valid) begin
        found = 1'b1;
        break;
      end
    end
    snap = pipe_if;
    checks++;
    if (!found || snap.vaddr !== 32'hBFC0_0000)
      $display("[TB] FAIL stall_first: got valid %b vaddr %h required 1 bfc00000", found, snap.vaddr);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (pipe_if !== snap) $display("[TB] FAIL stall_hold[%0d]: got %h required %h", i, pipe_if, snap);
      else passes++;
      checks++;
      if (ic_req_valid !== 1'b0) $display("[TB] FAIL stall_noreq[%0d]: got %b required 0", i, ic_req_valid);
      else passes++;
    end
    step();
    ready_i = 1'b1;
    wait_idle(50);
  endtask

  task automatic test_branch();
    reset_dut();
    push_both(32'hBFC0_0000);
    push_both(32'hBFC0_0004);
    credits = 2;
    wait_idle(50);
    br_valid = 1'b1;
    br_target = 32'h8000_0100;
    step();
    br_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ic_req_vaddr !== 32'hBFC0_0008)
      $display("[TB] FAIL br_delay_slot: got %h required bfc00008", ic_req_vaddr);
    else passes++;
    step();
    push_both(32'hBFC0_0008);
    push_both(32'h8000_0100);
    credits = 2;
    wait_idle(50);
  endtask

  task automatic test_branch_same_cycle();
    push_both(32'h8000_0104);
    credits = 1;
    step();
    br_valid = 1'b1;
    br_target = 32'h8000_0400;
    step();
    br_valid = 1'b0;
    wait_idle(50);
    @(negedge clk);
    checks++;
    if (ic_req_vaddr !== 32'h8000_0400)
      $display("[TB] FAIL br_same_cycle: got %h required 80000400", ic_req_vaddr);
    else passes++;
    step();
    push_both(32'h8000_0400);
    credits = 1;
    wait_idle(50);
  endtask

  task automatic test_exception();
    int base;
    reset_dut();
    ready_i = 1'b0;
    resp_lat = 2;
    exp_req.push_back(32'hBFC0_0000);
    exp_req.push_back(32'hBFC0_0004);
    exp_req.push_back(32'h8000_0180);
    exp_out.push_back(exp_item(32'h8000_0180));
    base = accept_count;
    credits = 2;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #3;
      if (accept_count >= base + 2) break;
    end
    checks++;
    if (pipe_if.valid !== 1'b1 || pipe_if.vaddr !== 32'hBFC0_0000)
      $display("[TB] FAIL exc_pre: got valid %b vaddr %h required 1 bfc00000", pipe_if.valid, pipe_if.vaddr);
    else passes++;
    except_req = '{valid: 1'b1, target: 32'h8000_0180};
    step();
    except_req = '0;
    ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (pipe_if !== '0) $display("[TB] FAIL exc_flush: got %h required 0", pipe_if);
    else passes++;
    checks++;
    if (ic_req_valid !== 1'b0) $display("[TB] FAIL exc_drop_req: got %b required 0", ic_req_valid);
    else passes++;
    checks++;
    if (ic_req_vaddr !== 32'h8000_0180) $display("[TB] FAIL exc_pc: got %h required 80000180", ic_req_vaddr);
    else passes++;
    repeat (5) step();
    resp_lat = 0;
    credits = 1;
    wait_idle(50);
  endtask

  task automatic test_except_branch();
    reset_dut();
    push_both(32'hBFC0_0000);
    credits = 1;
    wait_idle(50);
    except_req = '{valid: 1'b1, target: 32'h8000_0200};
    br_valid = 1'b1;
    br_target = 32'h8000_0300;
    step();
    except_req = '0;
    br_valid = 1'b0;
    push_both(32'h8000_0200);
    push_both(32'h8000_0204);
    credits = 2;
    wait_idle(50);
  endtask

`ifdef IF_ADDR_ERR_CHECK_EN
  task automatic test_addr_err();
    reset_dut();
    except_req = '{valid: 1'b1, target: 32'h8000_0182};
    step();
    except_req = '0;
    exp_out.push_back('{valid: 1'b1, vaddr: 32'h8000_0182, inst: 32'd0, adel: 1'b1});
    credits = 4;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (ic_req_valid !== 1'b0) $display("[TB] FAIL adel_noreq[%0d]: got %b required 0", i, ic_req_valid);
      else passes++;
    end
    step();
    credits = 0;
    wait_idle(20);
    @(negedge clk);
    checks++;
    if (pipe_if.valid !== 1'b0) $display("[TB] FAIL adel_once: got %b required 0", pipe_if.valid);
    else passes++;
    step();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_same_cycle();
    test_exception();
    test_except_branch();
`ifdef IF_ADDR_ERR_CHECK_EN
    test_addr_err();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
